shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Transmit sequencer for the LEN-bit parallel-load shift register. It accepts parallel words over a valid/ready handshake and drives the register's en, pl, din and si controls. Each word is parallel-loaded, shifted out for exactly LEN cycles, and followed by a programmable idle gap. It sits between a word producer and the shift register and makes it a framed serial transmitter.

Parameters:
LEN, 16, width of the controlled shift register and of the data words.
GAP, 2, idle cycles inserted after each word before the next one is accepted (0 allowed).
SI_FILL, 1'b0, constant value driven on sr_si while shifting.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
s_valid  input  1  producer has a word on s_data.
s_ready  output  1  controller can accept a word.
s_data  input  LEN  word to transmit.
abort  input  1  synchronous abort of the current frame.
sr_en  output  1  shift-register enable.
sr_pl  output  1  shift-register parallel-load select.
sr_din  output  LEN  shift-register parallel input (registered copy of the accepted word).
sr_si  output  1  shift-register serial input.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse on the final shift cycle of a frame.
bit_cnt  output  clog2(LEN)  index of the current shift cycle, 0..LEN-1.

Behaviour:
- Reset (async, any state): state=IDLE, s_ready=1 after release, sr_en=0, sr_pl=0, sr_din=0, sr_si=SI_FILL, busy=0, done=0, bit_cnt=0, gap counter=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from s_valid, s_data or abort to any output.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: s_ready=1, sr_en=0, sr_pl=0.
  - Handshake occurs when s_valid and s_ready are both high at a clock edge.
  - On handshake: sr_din<=s_data, then go to LOAD.
  - While s_valid=0, stay in IDLE.
- LEAD/LOAD: exactly 1 cycle. sr_pl=1, sr_en=1, s_ready=0. The shift register loads sr_din at the closing edge. Next state is SHIFT with bit_cnt=0.
- SHIFT: exactly LEN cycles.
  - Outputs: sr_en=1, sr_pl=0, sr_si=SI_FILL, s_ready=0.
  - bit_cnt increments each cycle.
  - On the cycle with bit_cnt==LEN-1, done=1.
  - At the end of that cycle, go to GAP if GAP>0, else IDLE. bit_cnt returns to 0.
- GAP: exactly GAP cycles. sr_en=0, sr_pl=0, s_ready=0. Then go to IDLE.
- Back-to-back throughput: one word per 1+LEN+GAP+1 cycles (IDLE accept cycle included). s_ready is never high outside IDLE.
- sr_din holds its value from one handshake until the next handshake. The producer may change s_data freely after the handshake.
- abort:
  - In LOAD, SHIFT or GAP: next state is IDLE. sr_en and sr_pl go to 0, bit_cnt goes to 0, no done pulse. The register contents are left as they are.
  - In IDLE: ignored. If abort and a handshake coincide in IDLE, the handshake wins.
- abort in the same cycle as bit_cnt==LEN-1: done still asserts that cycle (it is decoded from state). The next state is IDLE, with no GAP.
- Reset mid-frame: immediate return to reset values. The partially shifted word is dropped.
- LEN>=2 is required. bit_cnt width is clog2(LEN), minimum 1.

Test Plan:
1. rst=1 for 2 cycles, then release with s_valid=0 -> s_ready=1, busy=0, sr_en=0, sr_pl=0, sr_din=0 held for 10 cycles.
2. Send s_data=16'hA5C3 with s_valid for 1 cycle. Expected:
   - Next cycle: sr_pl=1, sr_en=1.
   - Then 16 cycles with sr_en=1, bit_cnt 0..15, done=1 only at bit_cnt=15.
   - A shift-register model's so then reads 1010010111000011, MSB first.
   - Then 2 GAP cycles, then s_ready=1.
3. Hold s_valid=1 with words 16'hFFFF then 16'h0001 -> second handshake occurs exactly 20 cycles after the first (1 IDLE + 1 LOAD + 16 SHIFT + 2 GAP). Each serial stream is correct.
4. Assert abort at bit_cnt=5 -> next cycle state=IDLE, sr_en=0, s_ready=1, no done pulse. A new word 16'h00FF is then transmitted intact.
5. Pulse rst at bit_cnt=9 mid-frame -> all outputs go to reset values asynchronously before the next clock edge. After release, the controller accepts a new word normally.
6. Parameter override LEN=8, GAP=0, SI_FILL=1 -> SHIFT lasts 8 cycles and sr_si=1. IDLE follows immediately after done, and back-to-back spacing is 10 cycles.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: transmit sequencer for a LEN-bit parallel-load shift register.
// Accepts words over valid/ready, then sequences load, LEN shifts and an idle gap.
module shift_reg_ctrl #(
    parameter int   LEN     = 16,
    parameter int   GAP     = 2,
    parameter logic SI_FILL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LEN-1:0]          s_data,
    input  logic                    abort,
    output logic                    sr_en,
    output logic                    sr_pl,
    output logic [LEN-1:0]          sr_din,
    output logic                    sr_si,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LEN)-1:0]  bit_cnt
);

    localparam int CW = $clog2(LEN);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sr_din  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (s_valid) begin
                        sr_din <= s_data;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bit_cnt <= '0;
                    state   <= abort ? S_IDLE : S_SHIFT;
                end
                S_SHIFT: begin
                    if (abort || bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        // abort on the last shift skips the gap entirely
                        state   <= (abort || GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (abort || gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // every output is a decode of registered state only
    assign s_ready = (state == S_IDLE);
    assign busy    = (state != S_IDLE);
    assign sr_en   = (state == S_LOAD) || (state == S_SHIFT);
    assign sr_pl   = (state == S_LOAD);
    assign sr_si   = SI_FILL;
    assign done    = (state == S_SHIFT) && (bit_cnt == CNT_LAST);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: scenario tasks plus random traffic, checked against a
// cycle-offset frame model and a serial shift-register model.
module tb_shift_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        s_valid_a, abort_a, s_ready_a;
    logic [15:0] s_data_a, sr_din_a;
    logic        sr_en_a, sr_pl_a, sr_si_a, busy_a, done_a;
    logic [3:0]  bit_cnt_a;

    logic        s_valid_b, abort_b, s_ready_b;
    logic [7:0]  s_data_b, sr_din_b;
    logic        sr_en_b, sr_pl_b, sr_si_b, busy_b, done_b;
    logic [2:0]  bit_cnt_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.LEN(16), .GAP(2), .SI_FILL(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .abort(abort_a),
        .sr_en(sr_en_a), .sr_pl(sr_pl_a), .sr_din(sr_din_a), .sr_si(sr_si_a),
        .busy(busy_a), .done(done_a), .bit_cnt(bit_cnt_a)
    );

    shift_reg_ctrl #(.LEN(8), .GAP(0), .SI_FILL(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .abort(abort_b),
        .sr_en(sr_en_b), .sr_pl(sr_pl_b), .sr_din(sr_din_b), .sr_si(sr_si_b),
        .busy(busy_b), .done(done_b), .bit_cnt(bit_cnt_b)
    );

    // frame model: t = cycles since handshake, -1 when idle
    int          ma_t = -1;
    int          mb_t = -1;
    logic [15:0] ma_word = '0;
    logic [7:0]  mb_word = '0;

    function automatic int nxt(input int t, input logic v, input logic ab,
                               input int len, input int gap);
        if (t < 0) return v ? 0 : -1;
        if (ab) return -1;
        if (t + 1 > len + gap) return -1;
        return t + 1;
    endfunction

    function automatic logic [25:0] mexp(input int len, input logic si,
                                         input int t, input logic [15:0] w);
        logic [3:0] c;
        c = (t >= 1 && t <= len) ? 4'(t - 1) : 4'd0;
        return {t < 0, t >= 0, t >= 0 && t <= len, t == 0, si, t == len, c, w};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_t <= -1; ma_word <= '0;
            mb_t <= -1; mb_word <= '0;
        end else begin
            if (ma_t < 0 && s_valid_a) ma_word <= s_data_a;
            if (mb_t < 0 && s_valid_b) mb_word <= s_data_b;
            ma_t <= nxt(ma_t, s_valid_a, abort_a, 16, 2);
            mb_t <= nxt(mb_t, s_valid_b, abort_b, 8, 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] exp_a, exp_b, obs_a, obs_b;
    assign exp_a = mexp(16, 1'b0, ma_t, ma_word);
    assign exp_b = mexp(8, 1'b1, mb_t, {8'h00, mb_word});
    assign obs_a = {s_ready_a, busy_a, sr_en_a, sr_pl_a, sr_si_a, done_a,
                    bit_cnt_a, sr_din_a};
    assign obs_b = {s_ready_b, busy_b, sr_en_b, sr_pl_b, sr_si_b, done_b,
                    1'b0, bit_cnt_b, 8'h00, sr_din_b};

    // external shift registers driven by the controllers; rx collects so
    logic [15:0] q_a, rx_a;
    logic [7:0]  q_b, rx_b;

    always @(posedge clk) begin
        if (sr_en_a && sr_pl_a) q_a <= sr_din_a;
        else if (sr_en_a) begin
            q_a  <= {q_a[14:0], sr_si_a};
            rx_a <= {rx_a[14:0], q_a[15]};
        end
        if (sr_en_b && sr_pl_b) q_b <= sr_din_b;
        else if (sr_en_b) begin
            q_b  <= {q_b[6:0], sr_si_b};
            rx_b <= {rx_b[6:0], q_b[7]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_valid_a = 0; abort_a = 0; s_data_a = '0;
        s_valid_b = 0; abort_b = 0; s_data_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL reset_a obs=%h exp=%h", obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin failures++;
                $display("FAIL reset_b obs=%h exp=%h", obs_b, exp_b); end
            checks++;
            if ({s_ready_a, busy_a, sr_en_a, sr_pl_a, sr_din_a} !== 20'h80000)
            begin failures++;
                $display("FAIL reset_const obs=%h exp=80000",
                         {s_ready_a, busy_a, sr_en_a, sr_pl_a, sr_din_a}); end
        end
    endtask

    task automatic test_single;
        int n_done = 0;
        s_valid_a = 1; s_data_a = 16'hA5C3;
        tick();
        s_valid_a = 0; s_data_a = 16'($urandom);
        checks++;
        if (obs_a !== exp_a) begin failures++;
            $display("FAIL single_load obs=%h exp=%h", obs_a, exp_a); end
        repeat (19) begin
            tick();
            if (done_a) n_done++;
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL single obs=%h exp=%h", obs_a, exp_a); end
        end
        checks++;
        if (rx_a !== 16'hA5C3) begin failures++;
            $display("FAIL single_serial got=%h exp=a5c3", rx_a); end
        checks++;
        if (n_done != 1) begin failures++;
            $display("FAIL single_done_count got=%0d exp=1", n_done); end
        checks++;
        if (s_ready_a !== 1'b1) begin failures++;
            $display("FAIL single_ready got=%b exp=1", s_ready_a); end
    endtask

    task automatic test_back_to_back;
        int hs[$];
        s_valid_a = 1; s_data_a = 16'hFFFF;
        for (int i = 0; i < 60 && hs.size() < 2; i++) begin
            if (s_ready_a) begin
                hs.push_back(cyc);
                if (hs.size() == 2) begin
                    checks++;
                    if (rx_a !== 16'hFFFF) begin failures++;
                        $display("FAIL b2b_serial1 got=%h exp=ffff", rx_a); end
                end
            end
            tick();
            if (hs.size() == 1) s_data_a = 16'h0001;
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL b2b obs=%h exp=%h", obs_a, exp_a); end
        end
        s_valid_a = 0;
        checks++;
        if (hs.size() != 2) begin failures++;
            $display("FAIL b2b_timeout handshakes=%0d exp=2", hs.size()); end
        else if (hs[1] - hs[0] != 20) begin failures++;
            $display("FAIL b2b_spacing got=%0d exp=20", hs[1] - hs[0]); end
        repeat (19) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL b2b_tail obs=%h exp=%h", obs_a, exp_a); end
        end
        checks++;
        if (rx_a !== 16'h0001) begin failures++;
            $display("FAIL b2b_serial2 got=%h exp=0001", rx_a); end
    endtask

    task automatic test_abort(input int at);
        logic found = 0;
        s_valid_a = 1; s_data_a = 16'($urandom);
        tick();
        s_valid_a = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL abort_pre obs=%h exp=%h", obs_a, exp_a); end
            if (sr_en_a && !sr_pl_a && bit_cnt_a == 4'(at)) found = 1;
        end
        checks++;
        if (!found) begin failures++;
            $display("FAIL abort_timeout bit_cnt=%0d exp=%0d", bit_cnt_a, at); end
        checks++;
        if (done_a !== (at == 15)) begin failures++;
            $display("FAIL abort_done got=%b exp=%b", done_a, at == 15); end
        abort_a = 1;
        tick();
        abort_a = 0;
        checks++;
        if ({s_ready_a, busy_a, sr_en_a, sr_pl_a, done_a, bit_cnt_a} !== 9'h100)
        begin failures++;
            $display("FAIL abort_idle obs=%h exp=100",
                     {s_ready_a, busy_a, sr_en_a, sr_pl_a, done_a, bit_cnt_a}); end
        repeat (3) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL abort_post obs=%h exp=%h", obs_a, exp_a); end
        end
        s_valid_a = 1; s_data_a = 16'h00FF;
        tick();
        s_valid_a = 0;
        repeat (19) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL abort_next obs=%h exp=%h", obs_a, exp_a); end
        end
        checks++;
        if (rx_a !== 16'h00FF) begin failures++;
            $display("FAIL abort_serial got=%h exp=00ff", rx_a); end
    endtask

    task automatic test_reset_mid;
        logic found = 0;
        s_valid_a = 1; s_data_a = 16'($urandom);
        tick();
        s_valid_a = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (sr_en_a && !sr_pl_a && bit_cnt_a == 4'd9) found = 1;
        end
        checks++;
        if (!found) begin failures++;
            $display("FAIL rstmid_timeout bit_cnt=%0d exp=9", bit_cnt_a); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_ready_a, busy_a, sr_en_a, sr_pl_a, sr_si_a, done_a,
             bit_cnt_a, sr_din_a} !== 26'h2000000) begin failures++;
            $display("FAIL rstmid_async obs=%h exp=2000000", obs_a); end
        checks++;
        if (obs_a !== exp_a) begin failures++;
            $display("FAIL rstmid_model obs=%h exp=%h", obs_a, exp_a); end
        tick();
        rst = 1'b0;
        s_valid_a = 1; s_data_a = 16'h1234;
        tick();
        s_valid_a = 0;
        repeat (19) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL rstmid_next obs=%h exp=%h", obs_a, exp_a); end
        end
        checks++;
        if (rx_a !== 16'h1234) begin failures++;
            $display("FAIL rstmid_serial got=%h exp=1234", rx_a); end
    endtask

    task automatic test_len8;
        int          hs[$];
        logic [7:0]  words[$];
        s_valid_b = 1; s_data_b = 8'($urandom);
        for (int i = 0; i < 60 && hs.size() < 4; i++) begin
            if (s_ready_b) begin
                hs.push_back(cyc);
                words.push_back(s_data_b);
                if (hs.size() >= 2) begin
                    checks++;
                    if (rx_b !== words[hs.size() - 2]) begin failures++;
                        $display("FAIL len8_serial got=%h exp=%h",
                                 rx_b, words[hs.size() - 2]); end
                    checks++;
                    if (hs[$] - hs[hs.size() - 2] != 10) begin failures++;
                        $display("FAIL len8_spacing got=%0d exp=10",
                                 hs[$] - hs[hs.size() - 2]); end
                end
            end
            tick();
            s_data_b = 8'($urandom);
            checks++;
            if (obs_b !== exp_b) begin failures++;
                $display("FAIL len8 obs=%h exp=%h", obs_b, exp_b); end
        end
        s_valid_b = 0;
        checks++;
        if (hs.size() != 4) begin failures++;
            $display("FAIL len8_timeout handshakes=%0d exp=4", hs.size()); end
        repeat (9) begin
            tick();
            checks++;
            if (obs_b !== exp_b) begin failures++;
                $display("FAIL len8_tail obs=%h exp=%h", obs_b, exp_b); end
        end
        checks++;
        if (words.size() == 4 && rx_b !== words[3]) begin failures++;
            $display("FAIL len8_serial_last got=%h exp=%h", rx_b, words[3]); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            s_valid_a = ($urandom_range(0, 3) != 0);
            s_data_a  = 16'($urandom);
            abort_a   = ($urandom_range(0, 15) == 0);
            s_valid_b = ($urandom_range(0, 1) != 0);
            s_data_b  = 8'($urandom);
            abort_b   = ($urandom_range(0, 11) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (obs_a !== exp_a) begin failures++;
                $display("FAIL rand_a cyc=%0d obs=%h exp=%h", cyc, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin failures++;
                $display("FAIL rand_b cyc=%0d obs=%h exp=%h", cyc, obs_b, exp_b); end
        end
        rst = 0; s_valid_a = 0; abort_a = 0; s_valid_b = 0; abort_b = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort(5);
        test_abort(15);
        test_reset_mid();
        test_len8();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
